// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle A-RISC core. Fetches from a 1-cycle synchronous IRAM and talks to DRAM through
// a req/ack handshake. Opcode 15 traps into a sticky error.
module cpu_mc #(
   parameter int unsigned W       = 8,
   parameter int unsigned NUM_GPR = 8,
   parameter int unsigned AW      = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   output logic          idle,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] iram_addr,
   input  logic [15:0]   iram_dout,
   output logic          dram_req,
   output logic          dram_write,
   output logic [W-1:0]  dram_addr,
   output logic [W-1:0]  dram_din,
   input  logic          dram_ack,
   input  logic [W-1:0]  dram_dout
);

   typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

   typedef enum logic [3:0] {
      OpEnd, OpAdd, OpSub, OpMul, OpDv2, OpLdm, OpStm, OpMvr,
      OpMvi, OpBeq, OpBlt, OpJmp, OpAnd, OpOr, OpXor, OpIll
   } op_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d, pc_inc, target;
   logic [15:0]   ir_q, ir_d, instr;
   logic [W-1:0]  di_q, di_d, ar_q, ar_d, jr_q, jr_d;
   logic [W-1:0]  gpr_q [NUM_GPR];
   logic [W-1:0]  gpr_d [NUM_GPR];
   logic          err_q, err_d;

   op_e           op;
   logic [3:0]    rd, ra, rb;
   logic [W-1:0]  imm, op_a, op_b, half, alu_res;
   logic [W-1:0]  rf [16];
   logic          mem_op, wr_en;

   // S_EXEC decodes straight off the IRAM; S_MEM decodes the latched copy.
   assign instr  = (state_q == StExec) ? iram_dout : ir_q;
   assign op     = op_e'(instr[3:0]);
   assign rd     = instr[7:4];
   assign ra     = instr[11:8];
   assign rb     = instr[15:12];
   assign pc_inc = pc_q + AW'(1);
   assign target = jr_q[AW-1:0];
   assign mem_op = ((state_q == StExec) || (state_q == StMem)) && ((op == OpLdm) || (op == OpStm));

   assign idle = (state_q == StIdle);
   assign err  = err_q;

   always_comb begin
      imm      = '0;
      imm[7:0] = {ra, rb};
   end

   always_comb begin
      for (int unsigned i = 0; i < 16; i++) rf[i] = '0;
      rf[1] = W'(1);
      rf[2] = di_q;
      rf[3] = imm;
      rf[4] = ar_q;
      rf[5] = jr_q;
      for (int unsigned g = 0; g < NUM_GPR; g++) rf[6+g] = gpr_q[g];
   end

   assign op_a = rf[ra];
   assign op_b = rf[rb];

   // Arithmetic shift floors; odd negatives need +1 to truncate toward zero.
   assign half = {op_a[W-1], op_a[W-1:1]} + {{(W-1){1'b0}}, op_a[W-1] & op_a[0]};

   always_comb begin
      alu_res = '0;
      case (op)
         OpAdd:   alu_res = op_a + op_b;
         OpSub:   alu_res = op_a - op_b;
         OpMul:   alu_res = op_a * op_b;
         OpDv2:   alu_res = half;
         OpMvr:   alu_res = op_a;
         OpMvi:   alu_res = imm;
         OpAnd:   alu_res = op_a & op_b;
         OpOr:    alu_res = op_a | op_b;
         OpXor:   alu_res = op_a ^ op_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      di_d       = di_q;
      ar_d       = ar_q;
      jr_d       = jr_q;
      gpr_d      = gpr_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      done       = 1'b0;
      iram_addr  = pc_q;
      dram_req   = 1'b0;
      dram_write = 1'b0;
      dram_addr  = '0;
      dram_din   = '0;

      if (mem_op) begin
         dram_req   = 1'b1;
         dram_write = (op == OpStm);
         dram_addr  = ar_q;
         dram_din   = op_a;
         if (dram_ack && (op == OpLdm)) di_d = dram_dout;
      end

      unique case (state_q)
         StIdle: begin
            iram_addr = '0;
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
               err_d   = 1'b0;
            end
         end
         StFetch: state_d = StExec;
         StExec: begin
            ir_d = iram_dout;
            case (op)
               OpEnd: begin
                  done    = 1'b1;
                  state_d = StIdle;
               end
               OpIll: begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
               OpLdm, OpStm: begin
                  if (dram_ack) begin
                     pc_d    = pc_inc;
                     state_d = StFetch;
                  end else begin
                     state_d = StMem;
                  end
               end
               OpBeq: begin
                  pc_d    = (op_a == op_b) ? target : pc_inc;
                  state_d = StFetch;
               end
               OpBlt: begin
                  pc_d    = ($signed(op_a) < $signed(op_b)) ? target : pc_inc;
                  state_d = StFetch;
               end
               OpJmp: begin
                  pc_d    = target;
                  state_d = StFetch;
               end
               default: begin
                  wr_en   = 1'b1;
                  pc_d    = pc_inc;
                  state_d = StFetch;
               end
            endcase
         end
         StMem: begin
            if (dram_ack) begin
               pc_d    = pc_inc;
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase

      // Selects 0-3 and unmapped selects silently drop the write.
      if (wr_en) begin
         if (rd == 4'd4) ar_d = alu_res;
         if (rd == 4'd5) jr_d = alu_res;
         for (int unsigned g = 0; g < NUM_GPR; g++) begin
            if (rd == 4'(6 + g)) gpr_d[g] = alu_res;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         di_q    <= '0;
         ar_q    <= '0;
         jr_q    <= '0;
         gpr_q   <= '{default: '0};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         di_q    <= di_d;
         ar_q    <= ar_d;
         jr_q    <= jr_d;
         gpr_q   <= gpr_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: IRAM model, scripted DRAM responder driven from a scoreboard queue.
module tb_cpu_mc;

   localparam int unsigned W       = 8;
   localparam int unsigned NUM_GPR = 8;
   localparam int unsigned AW      = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0;
   logic          idle, done, err;
   logic [AW-1:0] iram_addr;
   logic [15:0]   iram_dout;
   logic          dram_req, dram_write;
   logic [W-1:0]  dram_addr, dram_din;
   logic          dram_ack = 1'b0;
   logic [W-1:0]  dram_dout = '0;

   cpu_mc #(.W(W), .NUM_GPR(NUM_GPR), .AW(AW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .idle       (idle),
      .done       (done),
      .err        (err),
      .iram_addr  (iram_addr),
      .iram_dout  (iram_dout),
      .dram_req   (dram_req),
      .dram_write (dram_write),
      .dram_addr  (dram_addr),
      .dram_din   (dram_din),
      .dram_ack   (dram_ack),
      .dram_dout  (dram_dout)
   );

   always #5 clk = ~clk;

   logic [15:0] imem [256];
   always_ff @(posedge clk) iram_dout <= imem[iram_addr];

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] din;
      int         waits;
      logic [7:0] rdata;
   } xact_t;

   xact_t      exp_q[$];
   logic [7:0] path[$];
   logic [7:0] ep[$];
   int         total = 0;
   int         bad = 0;
   int         ndone;
   int         done_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb);
      return {rb, ra, rd, op};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   task automatic expect_x(input logic wr, input logic [7:0] addr, input logic [7:0] din,
                           input int waits, input logic [7:0] rdata);
      xact_t t;
      t.wr = wr; t.addr = addr; t.din = din; t.waits = waits; t.rdata = rdata;
      exp_q.push_back(t);
   endtask

   // Leaves the bench at the negedge inside the first cycle after the start edge.
   task automatic go();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run(input int max_cyc, input bit expect_end, input bit poke);
      bit    in_req = 1'b0;
      bit    ended = 1'b0;
      int    wcnt = 0;
      xact_t cur;
      cur.wr = 1'b0; cur.addr = '0; cur.din = '0; cur.waits = 0; cur.rdata = '0;
      ndone = 0;
      done_cyc = -1;
      path.delete();
      for (int c = 1; c <= max_cyc && !ended; c++) begin
         start = (poke && c == 3);
         if (idle) begin
            ended = 1'b1;
         end else begin
            if (done) begin
               ndone++;
               done_cyc = c;
            end
            if (path.size() == 0 || path[path.size()-1] != iram_addr) path.push_back(iram_addr);
            if (dram_req) begin
               if (!in_req) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_req", 32'(1), 32'(0));
                     cur.wr = 1'b0; cur.addr = '0; cur.din = '0; cur.waits = 0; cur.rdata = '0;
                  end else begin
                     cur = exp_q.pop_front();
                  end
                  in_req = 1'b1;
                  wcnt = 0;
               end
               chk("dram_write", 32'(dram_write), 32'(cur.wr));
               chk("dram_addr", 32'(dram_addr), 32'(cur.addr));
               chk("dram_din", 32'(dram_din), 32'(cur.din));
               if (wcnt == cur.waits) begin
                  dram_ack = 1'b1;
                  dram_dout = cur.rdata;
                  in_req = 1'b0;
               end else begin
                  dram_ack = 1'b0;
                  dram_dout = 8'($urandom);
                  wcnt++;
               end
            end else begin
               if (in_req) begin
                  chk("req_held", 32'(0), 32'(1));
                  in_req = 1'b0;
               end
               dram_ack = 1'($urandom_range(0, 1));
               dram_dout = 8'hEE;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      if (expect_end) begin
         chk("finished", 32'(ended), 32'(1));
         chk("sb_empty", 32'(exp_q.size()), 32'(0));
      end
   endtask

   task automatic check_path(input string tag, input logic [7:0] e[$]);
      chk({tag, "_len"}, 32'(path.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < path.size(); i++) chk(tag, 32'(path[i]), 32'(e[i]));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_idle"}, 32'(idle), 32'(1));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_req"}, 32'(dram_req), 32'(0));
      chk({tag, "_write"}, 32'(dram_write), 32'(0));
      chk({tag, "_addr"}, 32'(dram_addr), 32'(0));
      chk({tag, "_din"}, 32'(dram_din), 32'(0));
      chk({tag, "_iaddr"}, 32'(iram_addr), 32'(0));
   endtask

   initial begin
      clear_imem();
      #2 rstn = 1'b0;
      #2;
      check_idle_outputs("rst");
      chk("rst_err", 32'(err), 32'(0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // A: SUB result plus done timing
      imem[0] = ins(8, 6, 0, 5);
      imem[1] = ins(8, 7, 0, 3);
      imem[2] = ins(2, 8, 6, 7);
      imem[3] = ins(0, 0, 0, 0);
      go();
      run(40, 1, 0);
      chk("a_ndone", 32'(ndone), 32'(1));
      chk("a_done_cyc", 32'(done_cyc), 32'(8));
      chk("a_idle", 32'(idle), 32'(1));
      chk("a_err", 32'(err), 32'(0));
      ep = '{8'h00, 8'h01, 8'h02, 8'h03};
      check_path("a_path", ep);

      // B: ALU ops, stores with wait states, load into DI, discarded writes
      clear_imem();
      imem[0]  = ins(8, 4, 1, 0);    expect_x(1, 8'h10, 8'h02, 3, 8'h00);
      imem[1]  = ins(6, 0, 8, 0);
      imem[2]  = ins(8, 9, 0, 3);
      imem[3]  = ins(2, 6, 0, 9);
      imem[4]  = ins(4, 7, 6, 0);
      imem[5]  = ins(8, 10, 1, 0);
      imem[6]  = ins(3, 11, 10, 10);
      imem[7]  = ins(6, 0, 6, 0);    expect_x(1, 8'h10, 8'hFD, 0, 8'h00);
      imem[8]  = ins(8, 4, 1, 1);
      imem[9]  = ins(6, 0, 7, 0);    expect_x(1, 8'h11, 8'hFF, 1, 8'h00);
      imem[10] = ins(8, 4, 1, 2);
      imem[11] = ins(6, 0, 11, 0);   expect_x(1, 8'h12, 8'h00, 0, 8'h00);
      imem[12] = ins(5, 0, 0, 0);    expect_x(0, 8'h12, 8'h00, 2, 8'hA5);
      imem[13] = ins(14, 12, 6, 2);
      imem[14] = ins(13, 13, 10, 1);
      imem[15] = ins(12, 11, 2, 9);
      imem[16] = ins(1, 10, 12, 13);
      imem[17] = ins(8, 4, 1, 3);
      imem[18] = ins(6, 0, 2, 0);    expect_x(1, 8'h13, 8'hA5, 0, 8'h00);
      imem[19] = ins(6, 0, 12, 0);   expect_x(1, 8'h13, 8'h58, 0, 8'h00);
      imem[20] = ins(6, 0, 13, 0);   expect_x(1, 8'h13, 8'h11, 0, 8'h00);
      imem[21] = ins(6, 0, 11, 0);   expect_x(1, 8'h13, 8'h01, 0, 8'h00);
      imem[22] = ins(6, 0, 10, 0);   expect_x(1, 8'h13, 8'h69, 0, 8'h00);
      imem[23] = ins(1, 9, 6, 7);
      imem[24] = ins(6, 0, 9, 0);    expect_x(1, 8'h13, 8'hFC, 0, 8'h00);
      imem[25] = ins(8, 1, 7, 7);
      imem[26] = ins(1, 9, 1, 0);
      imem[27] = ins(6, 0, 9, 0);    expect_x(1, 8'h13, 8'h01, 0, 8'h00);
      imem[28] = ins(7, 12, 3, 12);
      imem[29] = ins(6, 0, 12, 0);   expect_x(1, 8'h13, 8'h3C, 0, 8'h00);
      imem[30] = ins(0, 0, 0, 0);
      go();
      run(200, 1, 1);
      chk("b_ndone", 32'(ndone), 32'(1));

      // C: branches, jump, pc wrap from 0xFF to 0x00
      clear_imem();
      imem[8'h00] = ins(9, 0, 13, 1);
      imem[8'h01] = ins(8, 5, 2, 0);
      imem[8'h02] = ins(2, 6, 0, 1);
      imem[8'h03] = ins(8, 7, 0, 0);
      imem[8'h04] = ins(10, 0, 6, 7);
      imem[8'h05] = ins(15, 0, 0, 0);
      imem[8'h20] = ins(9, 0, 6, 7);
      imem[8'h21] = ins(8, 5, 15, 14);
      imem[8'h22] = ins(10, 0, 7, 6);
      imem[8'h23] = ins(11, 0, 0, 0);
      imem[8'hFE] = ins(8, 13, 0, 1);
      imem[8'hFF] = ins(8, 5, 4, 0);
      imem[8'h40] = ins(0, 0, 0, 0);
      go();
      run(80, 1, 0);
      ep = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21, 8'h22, 8'h23,
             8'hFE, 8'hFF, 8'h00, 8'h40};
      check_path("c_path", ep);
      chk("c_ndone", 32'(ndone), 32'(1));
      chk("c_err", 32'(err), 32'(0));

      // D: illegal opcode at pc=3 traps without done or register write
      clear_imem();
      imem[0] = ins(8, 6, 0, 7);
      imem[1] = ins(8, 7, 0, 1);
      imem[2] = ins(1, 8, 6, 7);
      imem[3] = ins(15, 8, 6, 6);
      go();
      run(40, 1, 0);
      chk("d_err", 32'(err), 32'(1));
      chk("d_idle", 32'(idle), 32'(1));
      chk("d_ndone", 32'(ndone), 32'(0));
      ep = '{8'h00, 8'h01, 8'h02, 8'h03};
      check_path("d_path", ep);

      // E: restart clears err; reset lands while a load is stalled
      clear_imem();
      imem[0] = ins(8, 4, 5, 0);
      imem[1] = ins(6, 0, 8, 0);     expect_x(1, 8'h50, 8'h08, 0, 8'h00);
      imem[2] = ins(8, 4, 6, 0);
      imem[3] = ins(5, 0, 0, 0);     expect_x(0, 8'h60, 8'h00, 1000, 8'h00);
      go();
      chk("e_err_clr", 32'(err), 32'(0));
      chk("e_iaddr0", 32'(iram_addr), 32'(0));
      run(10, 0, 0);
      chk("e_pre_req", 32'(dram_req), 32'(1));
      chk("e_pre_addr", 32'(dram_addr), 32'(8'h60));
      #2 rstn = 1'b0;
      #1;
      check_idle_outputs("e_rst");
      chk("e_rst_err", 32'(err), 32'(0));
      @(negedge clk) rstn = 1'b1;
      chk("e_sb_empty", 32'(exp_q.size()), 32'(0));

      // F: every register observed through stores must be zero after reset
      clear_imem();
      imem[0] = ins(6, 0, 8, 0);     expect_x(1, 8'h00, 8'h00, 0, 8'h00);
      imem[1] = ins(6, 0, 2, 0);     expect_x(1, 8'h00, 8'h00, 0, 8'h00);
      imem[2] = ins(6, 0, 5, 0);     expect_x(1, 8'h00, 8'h00, 0, 8'h00);
      imem[3] = ins(6, 0, 4, 0);     expect_x(1, 8'h00, 8'h00, 0, 8'h00);
      imem[4] = ins(0, 0, 0, 0);
      go();
      run(40, 1, 0);
      chk("f_ndone", 32'(ndone), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
